// File: rtl/div_sched.sv
// Round-robin front end that shares one 32/16 restoring divider among N_REQ clients.
// Handles divide-by-zero locally and aborts a stalled divider with a watchdog.
module div_sched #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 40
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic                  div_clear,
    output logic                  div_start,
    output logic [31:0]           div_a,
    output logic [15:0]           div_b,
    input  logic                  div_busy,
    input  logic                  div_ready,
    input  logic [31:0]           div_q,
    input  logic [15:0]           div_r,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_q,
    output logic [15:0]           rsp_r,
    output logic                  rsp_dz,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              div_clear_q, div_clear_d;
    logic              div_start_q, div_start_d;
    logic [31:0]       div_a_q, div_a_d;
    logic [15:0]       div_b_q, div_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_q_q, rsp_q_d;
    logic [15:0]       rsp_r_q, rsp_r_d;
    logic              rsp_dz_q, rsp_dz_d;
    logic              rsp_err_q, rsp_err_d;

    logic              found;
    logic [ID_W-1:0]   pick, idx;
    logic [31:0]       sel_a;
    logic [15:0]       sel_b;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        sel_a = req_a[int'(pick)*32 +: 32];
        sel_b = req_b[int'(pick)*16 +: 16];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        gnt_d       = '0;
        div_clear_d = 1'b1;
        div_start_d = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_r_d     = rsp_r_q;
        rsp_dz_d    = rsp_dz_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    div_a_d     = sel_a;
                    div_b_d     = sel_b;
                    rsp_id_d    = pick;
                    gnt_d[pick] = 1'b1;
                    ptr_d       = (pick == ID_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    div_start_d = (sel_b != 16'd0);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                wd_d = '0;
                // Zero divisor never reaches the divider; answer comes from the operands.
                if (div_b_q == 16'd0) begin
                    rsp_q_d     = 32'hFFFF_FFFF;
                    rsp_r_d     = div_a_q[15:0];
                    rsp_dz_d    = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (div_ready && !div_busy) begin
                    rsp_q_d     = div_q;
                    rsp_r_d     = div_r;
                    rsp_dz_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wd_q == WD_W'(TIMEOUT)) begin
                    rsp_q_d     = '0;
                    rsp_r_d     = '0;
                    rsp_dz_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    div_clear_d = 1'b0;
                    state_d     = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wd_q        <= '0;
            gnt_q       <= '0;
            div_clear_q <= 1'b0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_dz_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            gnt_q       <= gnt_d;
            div_clear_q <= div_clear_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_r_q     <= rsp_r_d;
            rsp_dz_q    <= rsp_dz_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign gnt       = gnt_q;
    assign div_clear = div_clear_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_dz    = rsp_dz_q;
    assign rsp_err   = rsp_err_q;

endmodule
